// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: segment encodings and converter FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_pkg;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Indexed by BCD nibble. Codes 10..15 never come out of the converter and decode to blank.
  localparam logic [15:0][6:0] SEG_TABLE = {
    {6{7'h7F}},
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_DONE
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Latency: busy for N+1 cycles after an accepted load; done pulses in the last busy cycle.
// Backpressure: loads presented while busy are dropped, never queued.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [N-1:0]          value_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS+3:0]   bcd_o,
  output logic                  ovf_o
);

  localparam int BW = 4 * DIGITS + 4;
  localparam int CW = (N > 1) ? $clog2(N + 1) : 1;
  localparam int unsigned LIMIT = 10 ** DIGITS - 1;

  conv_state_t   state, state_nxt;
  logic [CW-1:0] shift_cnt;
  logic [BW-1:0] bcd;
  logic [BW-1:0] bcd_adj;
  logic [N-1:0]  bin;
  logic          ovf;
  logic          ovf_nxt;

  // The extra top nibble in bcd lets the final shift land without truncation.
  // Overflow is judged on the input value, not on the converted digits.
  assign ovf_nxt = (N + 32)'(value_i) > (N + 32)'(LIMIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: load starts N shift cycles, then one DONE cycle hands the result over.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (load_i) state_nxt = ST_CONVERT;
      ST_CONVERT: if (shift_cnt == CW'(N - 1)) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Add 3 to every nibble that is 5 or more, all nibbles in parallel.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else                       bcd_adj[4*i +: 4] = bcd[4*i +: 4];
    end
  end

  // Datapath: capture on load, then adjust-and-shift once per CONVERT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin       <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      shift_cnt <= '0;
    end else if (state == ST_IDLE && load_i) begin
      bin       <= value_i;
      bcd       <= '0;
      ovf       <= ovf_nxt;
      shift_cnt <= '0;
    end else if (state == ST_CONVERT) begin
      {bcd, bin} <= {bcd_adj, bin} << 1;
      shift_cnt  <= shift_cnt + CW'(1);
    end
  end

  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE);
  assign bcd_o  = bcd;
  assign ovf_o  = ovf;

endmodule

// File: rtl/seg7_scan_driver.sv
// Captures a binary value, converts it to BCD and scans it onto a multiplexed common-anode 7-segment display.
// Latency: new value visible N+2 cycles after load; an/seg registered, one digit slot per REFRESH_DIV cycles.
// Backpressure: load ignored while busy. Optional: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N           = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [N-1:0]      value_i,
  output logic              busy_o,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  conv_done;
  logic [4*DIGITS+3:0]   conv_bcd;
  logic                  conv_ovf;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic                  disp_ovf;
  logic [RW-1:0]         refresh_cnt;
  logic [DW-1:0]         dig_idx;
  logic [6:0]            seg_nxt;
  logic [DIGITS-1:0]     an_nxt;

  bin2bcd_seq #(
    .N      (N),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_i),
    .value_i (value_i),
    .busy_o  (busy_o),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  // Display register: digits and overflow are replaced together so no partial value is ever shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else if (conv_done) begin
      disp_bcd <= conv_bcd[4*DIGITS-1:0];
      disp_ovf <= conv_ovf;
    end
  end

  // Free-running scan: step to the next digit every REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      dig_idx     <= '0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      dig_idx     <= (dig_idx == DW'(DIGITS - 1)) ? '0 : dig_idx + DW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zero_from;
  logic              zero_run;

  // zero_from[i] is set when digit i and every digit above it are zero.
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (disp_bcd[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
  end
`endif

  // Decode the currently selected digit; overflow overrides everything with dashes.
  always_comb begin
    seg_nxt = SEG_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      if (DW'(i) == dig_idx) begin
        seg_nxt = SEG_TABLE[disp_bcd[4*i +: 4]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (i != 0 && zero_from[i]) seg_nxt = SEG_BLANK;
`endif
      end
    end
    if (disp_ovf) seg_nxt = SEG_DASH;
    an_nxt = ~(DIGITS'(1) << dig_idx);
  end

  // Register anode and segment together so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o  <= '1;
      seg_o <= SEG_BLANK;
    end else begin
      an_o  <= an_nxt;
      seg_o <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: reset/scan order, conversion timing, dropped loads,
// overflow dashes, leading zeros, back-to-back loads and reset during a conversion.
module tb_seg7_scan_driver;

  localparam logic [6:0] E0 = 7'b1000000;
  localparam logic [6:0] E1 = 7'b1111001;
  localparam logic [6:0] E2 = 7'b0100100;
  localparam logic [6:0] E3 = 7'b0110000;
  localparam logic [6:0] E5 = 7'b0010010;
  localparam logic [6:0] E7 = 7'b1111000;
  localparam logic [6:0] E8 = 7'b0000000;
  localparam logic [6:0] E9 = 7'b0010000;
  localparam logic [6:0] BLK  = 7'h7F;
  localparam logic [6:0] DASH = 7'b0111111;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BLK;
`else
  localparam logic [6:0] LZ = E0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, load2;
  logic [7:0] value, value2;
  logic       busy, busy2;
  logic [6:0] seg, seg2;
  logic [2:0] an;
  logic [1:0] an2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(value),
    .busy_o(busy), .seg_o(seg), .an_o(an)
  );

  seg7_scan_driver #(.N(8), .DIGITS(2), .REFRESH_DIV(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_i(load2), .value_i(value2),
    .busy_o(busy2), .seg_o(seg2), .an_o(an2)
  );

  task automatic load_val(input int which, input logic [7:0] v);
    @(negedge clk);
    if (which == 0) begin load = 1'b1; value = v; end
    else begin load2 = 1'b1; value2 = v; end
    @(negedge clk);
    load  = 1'b0;
    load2 = 1'b0;
  endtask

  task automatic wait_busy(input int which, output int n);
    n = 0;
    while (((which == 0) ? busy : busy2) && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic get_seg(input int which, input int d, output logic [6:0] s, output bit ok);
    logic [2:0] one3;
    logic [1:0] one2;
    one3 = 3'b001;
    one2 = 2'b01;
    ok = 1'b0;
    s  = 7'h00;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (which == 0 && an == ~(one3 << d)) begin ok = 1'b1; s = seg; end
      if (which == 1 && an2 == ~(one2 << d)) begin ok = 1'b1; s = seg2; end
    end
  endtask

  task automatic test_reset;
    logic [2:0] an_exp [3];
    an_exp = '{3'b110, 3'b101, 3'b011};
    rst_n = 1'b0; load = 1'b0; load2 = 1'b0; value = '0; value2 = '0;
    repeat (2) @(negedge clk);
    checks++; if (an !== 3'b111) begin errors++; $display("FAIL reset_an got %b want 111", an); end
    checks++; if (seg !== BLK) begin errors++; $display("FAIL reset_seg got %b want %b", seg, BLK); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (an !== an_exp[((k - 1) / 4) % 3]) begin
        errors++;
        $display("FAIL scan_an cycle %0d got %b want %b", k, an, an_exp[((k - 1) / 4) % 3]);
      end
      if (k == 1) begin
        checks++;
        if (seg !== E0) begin errors++; $display("FAIL first_seg got %b want %b", seg, E0); end
      end
    end
  endtask

  task automatic test_load_123;
    logic [6:0] exp [3];
    logic [6:0] s;
    bit ok;
    int n;
    exp = '{E3, E2, E1};
    load_val(0, 8'd123);
    wait_busy(0, n);
    checks++; if (n != 9) begin errors++; $display("FAIL busy_len_123 got %0d want 9", n); end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      get_seg(0, d, s, ok);
      checks++;
      if (!ok || s !== exp[d]) begin errors++; $display("FAIL load123_dig%0d got %b found %0d want %b", d, s, ok, exp[d]); end
    end
  endtask

  task automatic test_drop_while_busy;
    logic [6:0] exp [3];
    logic [6:0] s;
    bit ok;
    int n;
    exp = '{E0, E0, E2};
    @(negedge clk); load = 1'b1; value = 8'd200;
    @(negedge clk); load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      if (n == 2) begin load = 1'b1; value = 8'd45; end
      else load = 1'b0;
      n++;
      @(negedge clk);
    end
    load = 1'b0;
    checks++; if (n != 9) begin errors++; $display("FAIL drop_busy_len got %0d want 9", n); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_no_restart busy got %b want 0", busy); end
    for (int d = 0; d < 3; d++) begin
      get_seg(0, d, s, ok);
      checks++;
      if (!ok || s !== exp[d]) begin errors++; $display("FAIL drop_dig%0d got %b found %0d want %b", d, s, ok, exp[d]); end
    end
  endtask

  task automatic test_overflow;
    logic [6:0] s;
    bit ok;
    int n;
    load_val(1, 8'd255);
    wait_busy(1, n);
    checks++; if (n != 9) begin errors++; $display("FAIL ovf_busy_len got %0d want 9", n); end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      get_seg(1, d, s, ok);
      checks++;
      if (!ok || s !== DASH) begin errors++; $display("FAIL ovf_dig%0d got %b found %0d want %b", d, s, ok, DASH); end
    end
    load_val(1, 8'd99);
    wait_busy(1, n);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      get_seg(1, d, s, ok);
      checks++;
      if (!ok || s !== E9) begin errors++; $display("FAIL d2_99_dig%0d got %b found %0d want %b", d, s, ok, E9); end
    end
  endtask

  task automatic test_leading_zero;
    logic [6:0] exp [3];
    logic [6:0] s;
    bit ok;
    int n;
    exp = '{E7, LZ, LZ};
    load_val(0, 8'd7);
    wait_busy(0, n);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      get_seg(0, d, s, ok);
      checks++;
      if (!ok || s !== exp[d]) begin errors++; $display("FAIL lz7_dig%0d got %b found %0d want %b", d, s, ok, exp[d]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp [3];
    logic [6:0] s;
    bit ok;
    int n;
    exp = '{E0, E5, LZ};
    @(negedge clk); load = 1'b1; value = 8'd50;
    @(negedge clk);
    wait_busy(0, n);
    checks++; if (n != 9) begin errors++; $display("FAIL b2b_first_len got %0d want 9", n); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_retrigger busy got %b want 1", busy); end
    load = 1'b0;
    wait_busy(0, n);
    checks++; if (n != 9) begin errors++; $display("FAIL b2b_second_len got %0d want 9", n); end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      get_seg(0, d, s, ok);
      checks++;
      if (!ok || s !== exp[d]) begin errors++; $display("FAIL b2b_dig%0d got %b found %0d want %b", d, s, ok, exp[d]); end
    end
  endtask

  task automatic test_reset_mid_conversion;
    logic [6:0] exp0 [3];
    logic [6:0] exp88 [3];
    logic [6:0] s;
    bit ok;
    int n;
    exp0  = '{E0, LZ, LZ};
    exp88 = '{E8, E8, LZ};
    load_val(0, 8'd88);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (an !== 3'b111) begin errors++; $display("FAIL midrst_an got %b want 111", an); end
    checks++; if (seg !== BLK) begin errors++; $display("FAIL midrst_seg got %b want %b", seg, BLK); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      get_seg(0, d, s, ok);
      checks++;
      if (!ok || s !== exp0[d]) begin errors++; $display("FAIL midrst_zero_dig%0d got %b found %0d want %b", d, s, ok, exp0[d]); end
    end
    load_val(0, 8'd88);
    wait_busy(0, n);
    checks++; if (n != 9) begin errors++; $display("FAIL reload88_len got %0d want 9", n); end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      get_seg(0, d, s, ok);
      checks++;
      if (!ok || s !== exp88[d]) begin errors++; $display("FAIL reload88_dig%0d got %b found %0d want %b", d, s, ok, exp88[d]); end
    end
  endtask

  initial begin
    test_reset;
    test_load_123;
    test_drop_while_busy;
    test_overflow;
    test_leading_zero;
    test_back_to_back;
    test_reset_mid_conversion;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
